// File: rtl/mac_unit.sv
// Signed multiply-accumulate PE: actual_result = in_a * in_w + in_p, plus a registered copy.
// Optional MAC_SATURATE_EN: clamp the sum on signed overflow instead of wrapping.
module mac_unit #(
    parameter int A_WIDTH = 8,
    parameter int W_WIDTH = 8,
    parameter int P_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic signed [A_WIDTH-1:0] in_a,
    input  logic signed [W_WIDTH-1:0] in_w,
    input  logic signed [P_WIDTH-1:0] in_p,
    output logic signed [P_WIDTH-1:0] actual_result,
    output logic signed [P_WIDTH-1:0] out_result,
    output logic                      out_valid,
    output logic                      overflow
);
    localparam int PROD_W = A_WIDTH + W_WIDTH;

    generate
        if (P_WIDTH < PROD_W) begin : g_width_chk
            $error("mac_unit: P_WIDTH must be >= A_WIDTH + W_WIDTH");
        end
    endgenerate

    typedef struct packed {
        logic [P_WIDTH-1:0] res;
        logic               ovf;
        logic               vld;
    } mac_rsp_t;

    logic signed [PROD_W-1:0]  prod;
    logic signed [P_WIDTH-1:0] prod_ext;
    logic signed [P_WIDTH-1:0] wrap_sum;
    logic                      ovf;
    mac_rsp_t                  rsp_q;

    // Full-width product; the size cast sign-extends because prod is signed.
    assign prod     = in_a * in_w;
    assign prod_ext = P_WIDTH'(prod);
    assign wrap_sum = prod_ext + in_p;
    assign ovf      = (prod_ext[P_WIDTH-1] == in_p[P_WIDTH-1]) &&
                      (wrap_sum[P_WIDTH-1] != in_p[P_WIDTH-1]);

`ifdef MAC_SATURATE_EN
    localparam logic [P_WIDTH-1:0] SAT_MAX = {1'b0, {(P_WIDTH-1){1'b1}}};
    localparam logic [P_WIDTH-1:0] SAT_MIN = {1'b1, {(P_WIDTH-1){1'b0}}};

    // On overflow both operands share a sign, so in_p's sign picks the rail.
    always_comb begin
        actual_result = wrap_sum;
        if (ovf) begin
            actual_result = in_p[P_WIDTH-1] ? SAT_MIN : SAT_MAX;
        end
    end
`else
    assign actual_result = wrap_sum;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_q <= '0;
        end else if (in_valid) begin
            rsp_q.res <= actual_result;
            rsp_q.ovf <= ovf;
            rsp_q.vld <= 1'b1;
        end else begin
            rsp_q.vld <= 1'b0;
        end
    end

    assign out_result = rsp_q.res;
    assign overflow   = rsp_q.ovf;
    assign out_valid  = rsp_q.vld;

endmodule

// File: tb/tb_mac_unit.sv
// Randomized self-checking bench for mac_unit against an integer-arithmetic reference model.
module tb_mac_unit;
    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic signed [7:0]  in_a;
    logic signed [7:0]  in_w;
    logic signed [31:0] in_p;
    logic signed [31:0] actual_result;
    logic signed [31:0] out_result;
    logic               out_valid;
    logic               overflow;

    int nvec = 0;
    int nerr = 0;

    logic [31:0] m_res = '0;
    logic        m_vld = 1'b0;
    logic        m_ovf = 1'b0;

    mac_unit #(.A_WIDTH(8), .W_WIDTH(8), .P_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .in_a(in_a), .in_w(in_w), .in_p(in_p),
        .actual_result(actual_result), .out_result(out_result),
        .out_valid(out_valid), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference: exact integer sum, overflow = sum outside the signed 32-bit range.
    function automatic void model(input logic signed [7:0] a, input logic signed [7:0] w,
                                  input logic signed [31:0] p,
                                  output logic [31:0] r, output logic o);
        longint s;
        s = longint'(a) * longint'(w) + longint'(p);
        o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
`ifdef MAC_SATURATE_EN
        if (s > 64'sd2147483647)       r = 32'h7FFF_FFFF;
        else if (s < -64'sd2147483648) r = 32'h8000_0000;
        else                           r = s[31:0];
`else
        r = s[31:0];
`endif
    endfunction

    task automatic apply(input logic r, input logic v, input logic signed [7:0] a,
                         input logic signed [7:0] w, input logic signed [31:0] p);
        logic [31:0] er;
        logic        eo;
        @(negedge clk);
        rst = r; in_valid = v; in_a = a; in_w = w; in_p = p;
        #1;
        model(a, w, p, er, eo);
        chk("comb", actual_result, er);
        @(posedge clk);
        if (r) begin
            m_res = '0; m_ovf = 1'b0; m_vld = 1'b0;
        end else if (v) begin
            m_res = er; m_ovf = eo; m_vld = 1'b1;
        end else begin
            m_vld = 1'b0;
        end
        #1;
        chk("out_result", out_result, m_res);
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_vld});
        chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
    endtask

    initial begin
        logic signed [7:0]  a, w;
        logic signed [31:0] p;
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_w = '0; in_p = '0;
        // reset state
        apply(1'b1, 1'b0, 8'sd0, 8'sd0, 32'sd0);
        apply(1'b1, 1'b0, 8'sd3, 8'sd4, 32'sd5);
        // directed vectors
        apply(1'b0, 1'b0, 8'sd5, 8'sd10, 32'sd100);
        chk("t_150", actual_result, 32'd150);
        apply(1'b0, 1'b1, -8'sd5, 8'sd10, 32'sd100);
        chk("t_50", out_result, 32'd50);
        apply(1'b0, 1'b1, -8'sd5, -8'sd10, 32'sd100);
        apply(1'b0, 1'b1, 8'sd5, 8'sd10, -32'sd200);
        chk("t_m150", out_result, 32'hFFFF_FF6A);
        apply(1'b0, 1'b1, -8'sd5, -8'sd10, -32'sd100);
        apply(1'b0, 1'b1, 8'sd120, 8'sd0, -32'sd50);
        chk("t_zero", out_result, 32'hFFFF_FFCE);
        chk("t_zero_vld", {31'd0, out_valid}, 32'd1);
        apply(1'b0, 1'b0, 8'sd1, 8'sd2, 32'sd3);
        chk("t_hold_vld", {31'd0, out_valid}, 32'd0);
        chk("t_hold_res", out_result, 32'hFFFF_FFCE);
        apply(1'b0, 1'b1, -8'sd128, -8'sd128, 32'sd0);
        chk("t_minmin", out_result, 32'd16384);
        apply(1'b0, 1'b1, 8'sd1, 8'sd1, 32'sh7FFF_FFFF);
        chk("t_ovf_flag", {31'd0, overflow}, 32'd1);
        apply(1'b0, 1'b1, -8'sd1, 8'sd1, 32'sh8000_0000);
        apply(1'b0, 1'b0, -8'sd128, 8'sd127, 32'sh8000_0000);
        // reset mid-stream with in_valid high
        apply(1'b1, 1'b1, 8'sd7, 8'sd9, 32'sd1);
        chk("t_rst_vld", {31'd0, out_valid}, 32'd0);
        // randomized stream with occasional resets and extreme operands
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 3))
                0:       a = -8'sd128;
                1:       a = 8'sd127;
                default: a = 8'($urandom);
            endcase
            w = ($urandom_range(0, 5) == 0) ? -8'sd128 : 8'($urandom);
            case ($urandom_range(0, 3))
                0:       p = 32'sh7FFF_FFFF - 32'($urandom_range(0, 20000));
                1:       p = 32'sh8000_0000 + 32'($urandom_range(0, 20000));
                default: p = 32'($urandom);
            endcase
            apply($urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0, a, w, p);
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
